// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the 30/60 second countdown timer: FSM state
// encoding, default per-mode start values and a BCD clamp helper.
package countdown_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned MODE_A_TENS_DEF = 3;
    localparam int unsigned MODE_B_TENS_DEF = 6;

    // A tens value above 9 would put a non-BCD digit on the display.
    function automatic logic [3:0] tens_digit(input int unsigned tens);
        logic [3:0] d;
        d = (tens > 9) ? 4'd9 : tens[3:0];
        return d;
    endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Button/tick inputs and display/status outputs of the countdown timer,
// plus the FSM state as a debug observation point.
interface countdown_ctrl_if;
    import countdown_ctrl_pkg::*;

    // tick, btn_start and btn_mode are single-cycle pulses sampled on the
    // rising clock edge; there is no back-pressure, every pulse is consumed
    // (or deliberately dropped) in the cycle it is seen.
    logic       tick;
    logic       btn_start;
    logic       btn_mode;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       mode;
    logic       running;
    logic       done;
    state_t     state;

    modport master (
        output tick, btn_start, btn_mode,
        input  digit1, digit0, mode, running, done, state
    );

    modport slave (
        input  tick, btn_start, btn_mode,
        output digit1, digit0, mode, running, done, state
    );

endinterface

// File: rtl/countdown_ctrl_bcd_down2.sv
// Two-digit BCD down-counter with synchronous load and borrow from the
// ones digit into the tens digit; it stops at 00 instead of wrapping.
module bcd_down2 #(
    parameter logic [3:0] RESET_TENS = 4'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic       dec,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       last,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            digit1 <= RESET_TENS;
            digit0 <= 4'd0;
        end else if (load) begin
            digit1 <= load_tens;
            digit0 <= 4'd0;
        end else if (dec && !zero) begin
            if (digit0 == 4'd0) begin
                digit0 <= 4'd9;
                digit1 <= digit1 - 4'd1;
            end else begin
                digit0 <= digit0 - 4'd1;
            end
        end
    end

    // last flags the value whose decrement lands on 00.
    assign last = (digit1 == 4'd0) && (digit0 == 4'd1);
    assign zero = (digit1 == 4'd0) && (digit0 == 4'd0);

endmodule

// File: rtl/countdown_ctrl.sv
// Start/pause/mode control FSM for a 30/60 second countdown; the BCD
// count itself lives in bcd_down2.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int unsigned MODE_A_TENS = MODE_A_TENS_DEF,
    parameter int unsigned MODE_B_TENS = MODE_B_TENS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    countdown_ctrl_if.slave  bus
);

    localparam logic [3:0] TENS_A = tens_digit(MODE_A_TENS);
    localparam logic [3:0] TENS_B = tens_digit(MODE_B_TENS);

    state_t     state;
    logic       mode_q;
    logic       running_q;
    logic       done_q;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_last;
    logic       cnt_zero;
    logic [3:0] cnt_tens;
    logic [3:0] cnt_d1;
    logic [3:0] cnt_d0;

    // Counter controls mirror the FSM transitions below: btn_start always
    // outranks btn_mode and tick in the same cycle.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_tens = mode_q ? TENS_B : TENS_A;
        case (state)
            ST_IDLE: begin
                if (!bus.btn_start && bus.btn_mode) begin
                    cnt_load = 1'b1;
                    cnt_tens = mode_q ? TENS_A : TENS_B;
                end
            end
            ST_RUN: begin
                cnt_dec = bus.tick && !bus.btn_start;
            end
            ST_DONE: begin
                if (bus.btn_start) begin
                    cnt_load = 1'b1;
                end else if (bus.btn_mode) begin
                    cnt_load = 1'b1;
                    cnt_tens = mode_q ? TENS_A : TENS_B;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.btn_start) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                    end else if (bus.btn_mode) begin
                        mode_q <= ~mode_q;
                    end
                end
                ST_RUN: begin
                    if (bus.btn_start) begin
                        state     <= ST_PAUSE;
                        running_q <= 1'b0;
                    end else if (bus.tick && (cnt_last || cnt_zero)) begin
                        state     <= ST_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (bus.btn_start) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.btn_start) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b0;
                    end else if (bus.btn_mode) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b0;
                        mode_q <= ~mode_q;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    bcd_down2 #(
        .RESET_TENS (TENS_A)
    ) u_count (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_tens (cnt_tens),
        .dec       (cnt_dec),
        .digit1    (cnt_d1),
        .digit0    (cnt_d0),
        .last      (cnt_last),
        .zero      (cnt_zero)
    );

    assign bus.digit1  = cnt_d1;
    assign bus.digit0  = cnt_d0;
    assign bus.mode    = mode_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.state   = state;

endmodule
